// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions used by the fabric-facing blocks.
//   axi_resp_t : encoding of RRESP/BRESP
//   is_err()   : 1 for any response other than OKAY. EXOKAY counts as an error
//                because AXI4-Lite has no exclusive access.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_t;

  function automatic logic is_err(input axi_resp_t resp);
    return (resp != AXI_OKAY);
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle (AR, R, AW, W, B).
//   master modport : initiator side (drives valids on AR/AW/W, readies on R/B)
//   slave modport  : target side
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );

endinterface

// File: rtl/lsu_axi_lite_master.sv
// AXI4-Lite initiator: turns one request (read or write) into AXI4-Lite channel
// traffic and returns exactly one response. One transaction outstanding at a time.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   req_valid/req_ready: request handshake (ready only while idle)
//   req_we             : 1 = write, 0 = read
//   req_addr           : byte address, passed to araddr/awaddr unmodified
//   req_wdata/req_wstrb: write data and byte strobes
//   rsp_valid          : one-cycle response pulse
//   rsp_rdata          : read data (0 for writes), held until next response
//   rsp_err            : response was not OKAY, held until next response
//   m                  : AXI4-Lite master port
// Every AXI output comes straight from a flop, so no valid depends on a ready.
// There is deliberately no timeout: a silent slave stalls the block.
module lsu_axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  axi_lite_if.master          m
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_RESP
  } state_t;

  state_t              state;
  logic                req_ready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                rsp_valid_q;
  logic                aw_done;
  logic                w_done;
  logic                aw_done_nxt;
  logic                w_done_nxt;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  // A channel counts as done if it completed earlier or handshakes this cycle,
  // which lets AW and W finish in either order or together.
  assign aw_done_nxt = aw_done | (awvalid_q & m.awready);
  assign w_done_nxt  = w_done  | (wvalid_q  & m.wready);

  // Request payload: captured on accept, not reset (datapath only).
  always_ff @(posedge clk) begin
    if (req_valid && req_ready_q) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      req_ready_q <= 1'b1;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            if (req_we) begin
              state     <= S_WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end else begin
              state     <= S_RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end

        S_RD_ADDR: begin
          if (m.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (m.rvalid) begin
            rready_q    <= 1'b0;
            rsp_rdata   <= m.rdata;
            rsp_err     <= is_err(axi_resp_t'(m.rresp));
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end
        end

        S_WR_REQ: begin
          // Each valid drops the cycle after its own handshake.
          if (awvalid_q && m.awready) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (wvalid_q && m.wready) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if (aw_done_nxt && w_done_nxt) begin
            bready_q <= 1'b1;
            state    <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (m.bvalid) begin
            bready_q    <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= is_err(axi_resp_t'(m.bresp));
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end
        end

        S_RESP: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state       <= S_IDLE;
        end

        default: begin
          state       <= S_IDLE;
          req_ready_q <= 1'b1;
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          bready_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;

  assign m.araddr  = addr_q;
  assign m.arvalid = arvalid_q;
  assign m.rready  = rready_q;
  assign m.awaddr  = addr_q;
  assign m.awvalid = awvalid_q;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = wstrb_q;
  assign m.wvalid  = wvalid_q;
  assign m.bready  = bready_q;

endmodule

// File: tb/tb_lsu_axi_lite_master.sv
module tb_lsu_axi_lite_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bench slave ----------------
  int          ar_delay = 0;
  int          aw_delay = 0;
  int          w_delay = 0;
  logic        hold_r = 1'b0;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [1:0]  bresp_cfg = 2'b00;
  int          ar_wait, aw_wait, w_wait;
  logic [63:0] mtime;
  logic [31:0] mem [16];
  logic        aw_got, w_got;
  logic [31:0] aw_addr_l, wd_l;
  logic [3:0]  ws_l;
  logic        aw_hs, w_hs;
  logic [31:0] aw_addr_eff, wd_eff;
  logic [3:0]  ws_eff;

  assign bus.arready = bus.arvalid && (ar_wait >= ar_delay);
  assign bus.awready = bus.awvalid && (aw_wait >= aw_delay);
  assign bus.wready  = bus.wvalid  && (w_wait  >= w_delay);
  assign aw_hs       = bus.awvalid && bus.awready;
  assign w_hs        = bus.wvalid  && bus.wready;
  assign aw_addr_eff = aw_hs ? bus.awaddr : aw_addr_l;
  assign wd_eff      = w_hs  ? bus.wdata  : wd_l;
  assign ws_eff      = w_hs  ? bus.wstrb  : ws_l;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    if (a == 32'ha000_0048)           return mtime[31:0];
    else if (a == 32'ha000_004c)      return mtime[63:32];
    else if (a == 32'ha000_0100)      return 32'hbad0_0100;
    else if (a[31:8] == 24'h80_0000)  return mem[a[5:2]];
    else                              return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mtime      <= '0;
      ar_wait    <= 0;
      aw_wait    <= 0;
      w_wait     <= 0;
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.rresp  <= 2'b00;
      bus.bvalid <= 1'b0;
      bus.bresp  <= 2'b00;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      aw_addr_l  <= '0;
      wd_l       <= '0;
      ws_l       <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= (i == 1) ? 32'h0bad_cafe : 32'h0;
    end else begin
      mtime   <= mtime + 64'd1;
      ar_wait <= (bus.arvalid && !bus.arready) ? ar_wait + 1 : 0;
      aw_wait <= (bus.awvalid && !bus.awready) ? aw_wait + 1 : 0;
      w_wait  <= (bus.wvalid  && !bus.wready)  ? w_wait + 1  : 0;
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (bus.arvalid && bus.arready && !hold_r) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= slave_read(bus.araddr);
        bus.rresp  <= rresp_cfg;
      end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (aw_hs) aw_addr_l <= bus.awaddr;
      if (w_hs) begin
        wd_l <= bus.wdata;
        ws_l <= bus.wstrb;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        if (aw_addr_eff[31:8] == 24'h80_0000)
          mem[aw_addr_eff[5:2]] <= merge(mem[aw_addr_eff[5:2]], wd_eff, ws_eff);
        bus.bvalid <= 1'b1;
        bus.bresp  <= bresp_cfg;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
      end else begin
        aw_got <= aw_got || aw_hs;
        w_got  <= w_got  || w_hs;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } exp_t;
  exp_t        sb[$];
  int          acc_q[$];
  int          rsp_q[$];
  int          overlap = 0;
  int          aw_hi = 0;
  int          w_hi = 0;
  int          rsp_cnt = 0;
  int          multi = 0;
  logic        prev_rsp = 1'b0;
  logic [31:0] last_rdata = '0;

  always @(negedge clk) begin
    exp_t e;
    if (bus.arvalid && (bus.awvalid || bus.wvalid)) overlap++;
    if (bus.awvalid) aw_hi++;
    if (bus.wvalid) w_hi++;
    if (rsp_valid) begin
      rsp_cnt++;
      if (prev_rsp) multi++;
      rsp_q.push_back(cyc);
      last_rdata = rsp_rdata;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: rsp_valid with no request outstanding at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (rsp_err !== e.err) begin
          errors++;
          $display("FAIL rsp_err: got %0b expected %0b at cycle %0d", rsp_err, e.err, cyc);
        end
        if (e.chk) begin
          checks++;
          if (rsp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL rsp_rdata: got %h expected %h at cycle %0d", rsp_rdata, e.rdata, cyc);
          end
        end
      end
    end
    prev_rsp = rsp_valid;
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] exp_rdata,
                       input logic exp_err, input logic chk);
    exp_t e;
    int   n;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.chk   = chk;
    sb.push_back(e);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: req_ready=%0b required 1 within 100 cycles", req_ready);
    end else begin
      acc_q.push_back(cyc);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 7;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b expected 1", req_ready); end
    if (bus.arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %0b expected 0", bus.arvalid); end
    if ({bus.awvalid, bus.wvalid} !== 2'b00) begin errors++; $display("FAIL reset_aw_w_valid: got %b expected 00", {bus.awvalid, bus.wvalid}); end
    if ({bus.rready, bus.bready} !== 2'b00) begin errors++; $display("FAIL reset_readies: got %b expected 00", {bus.rready, bus.bready}); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %0b expected 0", rsp_err); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clint_read();
    logic [31:0] r1, r2;
    repeat (100) @(negedge clk);
    issue(1'b0, 32'ha000_0048, '0, '0, '0, 1'b0, 1'b0);
    wait_done();
    r1 = last_rdata;
    issue(1'b0, 32'ha000_0048, '0, '0, '0, 1'b0, 1'b0);
    wait_done();
    r2 = last_rdata;
    checks += 2;
    if (r1 < 32'd100) begin errors++; $display("FAIL mtime_lo_first: got %0d expected >= 100", r1); end
    if (r2 <= r1) begin errors++; $display("FAIL mtime_monotonic: second %0d expected > first %0d", r2, r1); end
    issue(1'b0, 32'ha000_004c, '0, '0, 32'h0, 1'b0, 1'b1);
    wait_done();
  endtask

  task automatic test_read_slverr();
    int c0;
    c0 = rsp_cnt;
    rresp_cfg = 2'b10;
    issue(1'b0, 32'ha000_0100, '0, '0, 32'hbad0_0100, 1'b1, 1'b1);
    wait_done();
    rresp_cfg = 2'b00;
    checks += 2;
    if (rsp_cnt - c0 != 1) begin errors++; $display("FAIL slverr_rsp_count: got %0d expected 1", rsp_cnt - c0); end
    if (multi != 0) begin errors++; $display("FAIL rsp_pulse_width: %0d multi-cycle pulses, expected 0", multi); end
  endtask

  task automatic test_write_order();
    int a0, w0;
    // W accepted immediately, AW accepted 3 cycles after awvalid rises
    aw_delay = 3; w_delay = 0;
    a0 = aw_hi; w0 = w_hi;
    issue(1'b1, 32'h8000_0000, 32'hdead_beef, 4'hf, 32'h0, 1'b0, 1'b1);
    wait_done();
    checks += 2;
    if (aw_hi - a0 != 4) begin errors++; $display("FAIL w_first_awvalid_cycles: got %0d expected 4", aw_hi - a0); end
    if (w_hi - w0 != 1) begin errors++; $display("FAIL w_first_wvalid_cycles: got %0d expected 1", w_hi - w0); end
    // AW first, W 3 cycles late
    aw_delay = 0; w_delay = 3;
    a0 = aw_hi; w0 = w_hi;
    issue(1'b1, 32'h8000_0008, 32'hcafe_f00d, 4'hf, 32'h0, 1'b0, 1'b1);
    wait_done();
    checks += 2;
    if (aw_hi - a0 != 1) begin errors++; $display("FAIL aw_first_awvalid_cycles: got %0d expected 1", aw_hi - a0); end
    if (w_hi - w0 != 4) begin errors++; $display("FAIL aw_first_wvalid_cycles: got %0d expected 4", w_hi - w0); end
    w_delay = 0;
    issue(1'b0, 32'h8000_0000, '0, '0, 32'hdead_beef, 1'b0, 1'b1);
    issue(1'b0, 32'h8000_0008, '0, '0, 32'hcafe_f00d, 1'b0, 1'b1);
    wait_done();
  endtask

  task automatic test_back_to_back();
    acc_q.delete();
    rsp_q.delete();
    issue(1'b0, 32'h8000_0004, '0, '0, 32'h0bad_cafe, 1'b0, 1'b1);
    issue(1'b1, 32'h8000_0004, 32'h1234_5678, 4'b0011, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h8000_0004, '0, '0, 32'h0bad_5678, 1'b0, 1'b1);
    wait_done();
    checks++;
    if (acc_q.size() != 3 || rsp_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_counts: accepts %0d responses %0d expected 3 and 3", acc_q.size(), rsp_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rsp_q[i] - acc_q[i] != 3) begin
          errors++;
          $display("FAIL b2b_latency%0d: got %0d cycles expected 3", i, rsp_q[i] - acc_q[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_q[i] - acc_q[i-1] != 4) begin
          errors++;
          $display("FAIL b2b_accept_gap%0d: got %0d cycles expected 4", i, acc_q[i] - acc_q[i-1]);
        end
      end
    end
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL ar_aw_overlap: got %0d cycles expected 0", overlap); end
  endtask

  task automatic test_write_decerr();
    bresp_cfg = 2'b11;
    issue(1'b1, 32'h8000_000c, 32'h5555_aaaa, 4'hf, 32'h0, 1'b1, 1'b1);
    wait_done();
    bresp_cfg = 2'b00;
  endtask

  task automatic test_reset_mid_read();
    int n, c0;
    hold_r = 1'b1;
    c0 = rsp_cnt;
    issue(1'b0, 32'h8000_0000, '0, '0, '0, 1'b0, 1'b0);
    n = 0;
    while (bus.rready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.rready !== 1'b1) begin errors++; $display("FAIL mid_read_rready: got %0b expected 1", bus.rready); end
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    checks += 3;
    if ({bus.arvalid, bus.awvalid, bus.wvalid} !== 3'b000) begin
      errors++; $display("FAIL abort_valids: got %b expected 000", {bus.arvalid, bus.awvalid, bus.wvalid});
    end
    if ({bus.rready, bus.bready} !== 2'b00) begin
      errors++; $display("FAIL abort_readies: got %b expected 00", {bus.rready, bus.bready});
    end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_rsp_valid: got %0b expected 0", rsp_valid); end
    reset = 1'b0;
    hold_r = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_ready: got %0b expected 1", req_ready); end
    repeat (5) @(negedge clk);
    checks++;
    if (rsp_cnt != c0) begin errors++; $display("FAIL abort_no_rsp: got %0d responses expected 0", rsp_cnt - c0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clint_read();
    test_read_slverr();
    test_write_order();
    test_back_to_back();
    test_write_decerr();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
